mem_data_demux_dr: RTL and testbench
====================================

// Module: mem_data_demux_dr
// PURPOSE
//  Dual-rail memory-data demultiplexer for the fetch/execute datapath.
//  Phase rail PH0 steers the memory data bus D to one of two consumers:
//  PH0=1 routes D to the instruction bus I; PH0=0 routes D to the
//  computation-data bus C. The bus not selected stays NULL.
//  Rail encoding per bit (x_t,x_f): 00=NULL, 01=DATA0, 10=DATA1, 11=ILLEGAL.
//  Outputs are registered on clk, with NCL-style hysteresis, for use in the
//  clocked emulation of the NCL pipeline.
// PARAMETERS
//  WIDTH  1  number of dual-rail data bits on D, I and C
// PORTS
//  clk    in   1      system clock, rising edge
//  rst_n  in   1      asynchronous active-low reset
//  PH0_t  in   1      phase select, true rail
//  PH0_f  in   1      phase select, false rail
//  D7_t   in   WIDTH  memory data, true rails
//  D7_f   in   WIDTH  memory data, false rails
//  I7_t   out  WIDTH  instruction output, true rails
//  I7_f   out  WIDTH  instruction output, false rails
//  C7_t   out  WIDTH  computation-data output, true rails
//  C7_f   out  WIDTH  computation-data output, false rails
//  ko     out  1      completion: 1 = outputs NULL (ready for data), 0 = DATA held
//  err    out  1      sticky flag: ILLEGAL code seen on PH0 or any D bit
// BEHAVIOUR
//  - Reset (rst_n=0, async): I7_*, C7_* = 0 (NULL), ko=1, err=0. Held while low.
//  - Input set DATA-complete: PH0 DATA and every D bit DATA.
//    Input set NULL-complete: PH0 NULL and every D bit NULL.
//  - State NULL_HOLD (outputs NULL, ko=1):
//    - On a clk edge with DATA-complete input, load in one cycle and move
//      to DATA_HOLD:
//      - PH0=1: I7 = D7, C7 = NULL.
//      - PH0=0: C7 = D7, I7 = NULL.
//      - ko=0.
//    - Otherwise hold.
//  - State DATA_HOLD (outputs frozen, ko=0):
//    - Inputs changing, partially NULL or partially DATA have no effect
//      (hysteresis).
//    - On a clk edge with NULL-complete input, all outputs go NULL, ko=1,
//      and the state returns to NULL_HOLD.
//  - Latency: one clk edge for either transition. Minimum DATA->NULL->DATA
//    turnaround is 2 cycles.
//  - Mixed inputs (some DATA, some NULL) never produce DATA on any output.
//  - ILLEGAL (11) on PH0 or any D bit:
//    - The input set is counted neither DATA- nor NULL-complete.
//    - err is set on that edge and stays set until reset.
//    - State and outputs are unchanged.
//  - Output invariants, every cycle:
//    - No output bit is ever 11.
//    - I7 and C7 are never DATA together.
//    - In DATA_HOLD, every bit of exactly one bus is DATA.
//  - Reset asserted mid-DATA_HOLD forces NULL immediately, asynchronously.
//    After rst_n rises, the first DATA-complete edge loads normally.
// TESTING
//  - Reset: rst_n=0 -> all outputs 00, ko=1, err=0. Release with inputs
//    NULL -> unchanged.
//  - PH0=0 (01), D7=0 (01), 1 edge -> C7=01, I7=00, ko=0. Then all NULL,
//    1 edge -> C7=00, ko=1.
//  - PH0=0, D7=1 (10) -> C7=10, I7=00.
//    PH0=1 (10), D7=0 -> I7=01, C7=00.
//    PH0=1, D7=1 -> I7=10, C7=00.
//    Each case separated by a NULL phase.
//  - Hysteresis:
//    - In DATA_HOLD, set PH0 to NULL only, or flip D7 -> outputs unchanged
//      for 3 cycles.
//    - Then make all inputs NULL -> outputs NULL next edge.
//  - Partial DATA from NULL_HOLD (PH0 DATA, D7 NULL) for 3 cycles ->
//    outputs stay NULL, ko=1.
//  - D7=11 with PH0=01 -> err=1 (sticky), outputs unchanged.
//    rst_n pulse -> err=0.
//    Async reset mid-DATA_HOLD -> outputs NULL without a clk edge.

Source files
------------

// File: rtl/mem_data_demux_dr.sv
// Dual-rail memory-data demultiplexer with NCL-style hysteresis.
// PH0 steers D to the instruction bus (PH0=1) or the computation bus (PH0=0).
module mem_data_demux_dr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PH0_t,
  input  logic             PH0_f,
  input  logic [WIDTH-1:0] D7_t,
  input  logic [WIDTH-1:0] D7_f,
  output logic [WIDTH-1:0] I7_t,
  output logic [WIDTH-1:0] I7_f,
  output logic [WIDTH-1:0] C7_t,
  output logic [WIDTH-1:0] C7_f,
  output logic             ko,
  output logic             err
);

  typedef enum logic {
    NULL_HOLD = 1'b0,
    DATA_HOLD = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] i_t_q, i_t_d;
  logic [WIDTH-1:0] i_f_q, i_f_d;
  logic [WIDTH-1:0] c_t_q, c_t_d;
  logic [WIDTH-1:0] c_f_q, c_f_d;
  logic             err_q, err_d;

  logic ill;
  logic data_cmp;
  logic null_cmp;

  // Classify the input set; an ILLEGAL rail pair disqualifies both completions.
  always_comb begin
    ill      = (PH0_t & PH0_f) | (|(D7_t & D7_f));
    data_cmp = ~ill & (PH0_t ^ PH0_f) & (&(D7_t ^ D7_f));
    null_cmp = ~ill & ~PH0_t & ~PH0_f & ~(|(D7_t | D7_f));
  end

  // Next-state and output-register update with hysteresis.
  always_comb begin
    state_d = state_q;
    i_t_d   = i_t_q;
    i_f_d   = i_f_q;
    c_t_d   = c_t_q;
    c_f_d   = c_f_q;
    err_d   = err_q | ill;
    unique case (state_q)
      NULL_HOLD: begin
        if (data_cmp) begin
          state_d = DATA_HOLD;
          if (PH0_t) begin
            i_t_d = D7_t;
            i_f_d = D7_f;
          end else begin
            c_t_d = D7_t;
            c_f_d = D7_f;
          end
        end
      end
      DATA_HOLD: begin
        if (null_cmp) begin
          state_d = NULL_HOLD;
          i_t_d   = '0;
          i_f_d   = '0;
          c_t_d   = '0;
          c_f_d   = '0;
        end
      end
      default: begin
        state_d = NULL_HOLD;
        i_t_d   = '0;
        i_f_d   = '0;
        c_t_d   = '0;
        c_f_d   = '0;
      end
    endcase
  end

  // State and output registers; reset forces NULL immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NULL_HOLD;
      i_t_q   <= '0;
      i_f_q   <= '0;
      c_t_q   <= '0;
      c_f_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_t_q   <= i_t_d;
      i_f_q   <= i_f_d;
      c_t_q   <= c_t_d;
      c_f_q   <= c_f_d;
      err_q   <= err_d;
    end
  end

  assign I7_t = i_t_q;
  assign I7_f = i_f_q;
  assign C7_t = c_t_q;
  assign C7_f = c_f_q;
  assign ko   = (state_q == NULL_HOLD);
  assign err  = err_q;

endmodule

// File: tb/tb_mem_data_demux_dr.sv
// Directed-vector bench for mem_data_demux_dr (WIDTH=1).
// Expected values are hand-computed rail codes.
module tb_mem_data_demux_dr;

  logic clk = 1'b0;
  logic rst_n;
  logic PH0_t, PH0_f;
  logic [0:0] D7_t, D7_f;
  logic [0:0] I7_t, I7_f, C7_t, C7_f;
  logic ko, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_data_demux_dr #(.WIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .PH0_t(PH0_t), .PH0_f(PH0_f),
    .D7_t(D7_t), .D7_f(D7_f),
    .I7_t(I7_t), .I7_f(I7_f),
    .C7_t(C7_t), .C7_f(C7_f),
    .ko(ko), .err(err)
  );

  typedef struct {
    logic [1:0] ph;
    logic [1:0] d;
    logic [1:0] ei;
    logic [1:0] ec;
    logic       eko;
    logic       eerr;
  } vec_t;

  vec_t tbl [22];

  task automatic drive(input logic [1:0] ph, input logic [1:0] d);
    {PH0_t, PH0_f} = ph;
    {D7_t, D7_f}   = d;
  endtask

  task automatic check(input string name, input logic [1:0] ei,
                       input logic [1:0] ec, input logic eko,
                       input logic eerr);
    logic [5:0] act, exp;
    act = {I7_t, I7_f, C7_t, C7_f, ko, err};
    exp = {ei, ec, eko, eerr};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got I=%b C=%b ko=%b err=%b want I=%b C=%b ko=%b err=%b",
               name, act[5:4], act[3:2], act[1], act[0],
               ei, ec, eko, eerr);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0};
    tbl[1]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[2]  = '{2'b01, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0};
    tbl[3]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[4]  = '{2'b10, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0};
    tbl[5]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[6]  = '{2'b10, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0};
    tbl[7]  = '{2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0};
    tbl[8]  = '{2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0};
    tbl[9]  = '{2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0};
    tbl[10] = '{2'b10, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0};
    tbl[11] = '{2'b01, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0};
    tbl[12] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[13] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[14] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[15] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[16] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[17] = '{2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[18] = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0};
    tbl[19] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[20] = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0};
    tbl[21] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};

    rst_n = 1'b0;
    drive(2'b00, 2'b00);
    #12;
    check("reset", 2'b00, 2'b00, 1'b1, 1'b0);
    drive(2'b10, 2'b10);
    step();
    check("reset_held", 2'b00, 2'b00, 1'b1, 1'b0);
    drive(2'b00, 2'b00);
    rst_n = 1'b1;
    step();
    check("release", 2'b00, 2'b00, 1'b1, 1'b0);

    for (int k = 0; k < 22; k++) begin
      drive(tbl[k].ph, tbl[k].d);
      step();
      check($sformatf("vec%0d", k), tbl[k].ei, tbl[k].ec,
            tbl[k].eko, tbl[k].eerr);
    end

    drive(2'b01, 2'b11);
    step();
    check("ill_null", 2'b00, 2'b00, 1'b1, 1'b1);
    drive(2'b00, 2'b00);
    step();
    check("err_sticky", 2'b00, 2'b00, 1'b1, 1'b1);
    drive(2'b01, 2'b10);
    step();
    check("load_after_err", 2'b00, 2'b10, 1'b0, 1'b1);
    drive(2'b11, 2'b01);
    step();
    check("ill_ph_hold", 2'b00, 2'b10, 1'b0, 1'b1);
    drive(2'b00, 2'b11);
    step();
    check("ill_d_no_null", 2'b00, 2'b10, 1'b0, 1'b1);

    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 2'b00, 2'b00, 1'b1, 1'b0);
    drive(2'b00, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_idle", 2'b00, 2'b00, 1'b1, 1'b0);
    drive(2'b10, 2'b10);
    step();
    check("post_rst_load", 2'b10, 2'b00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
